// File: rtl/merge_crossfade_scheduler_if.sv
// Stream and merger handshake bundle for merge_crossfade_scheduler.
//   s1_*/s2_*        : pixel streams ({R,G,B}, R in [23:16]) with valid/ready
//   m_valid/m_rgb*   : pair issued to the merger (drives both data valids)
//   weight1/weight2  : merger blend weights
//   merger_out_valid : merger result strobe, one per issued pair
// slave  : scheduler side
// master : stream source / merger side
interface merge_crossfade_scheduler_if;
  logic        s1_valid;
  logic [23:0] s1_rgb;
  logic        s1_ready;
  logic        s2_valid;
  logic [23:0] s2_rgb;
  logic        s2_ready;
  logic        m_valid;
  logic [23:0] m_rgb1;
  logic [23:0] m_rgb2;
  logic [7:0]  weight1;
  logic [7:0]  weight2;
  logic        merger_out_valid;

  modport slave (
    input  s1_valid, s1_rgb, s2_valid, s2_rgb, merger_out_valid,
    output s1_ready, s2_ready, m_valid, m_rgb1, m_rgb2, weight1, weight2
  );

  modport master (
    output s1_valid, s1_rgb, s2_valid, s2_rgb, merger_out_valid,
    input  s1_ready, s2_ready, m_valid, m_rgb1, m_rgb2, weight1, weight2
  );
endinterface

// File: rtl/merge_crossfade_scheduler.sv
// Crossfade scheduler: buffers two pixel streams in 4-deep FIFOs, issues
// pixel pairs to a blending merger with a bounded number in flight, and steps
// the blend weight once per frame until it saturates at 255.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : pulse that begins a crossfade sequence (honoured in idle only)
//   bus       : stream inputs, merger pair output, weights, merger result strobe
//   busy      : sequence in progress (run / drain / step)
//   done      : one-cycle pulse at end of sequence
//   frame_cnt : index of the frame currently being blended
module merge_crossfade_scheduler #(
  parameter int unsigned FRAME_PIXELS = 16,
  parameter int unsigned STEP         = 8,
  parameter int unsigned MAX_OUT      = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  merge_crossfade_scheduler_if.slave  bus,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  frame_cnt
);

  localparam int unsigned CntW = $clog2(FRAME_PIXELS + 1);
  localparam int unsigned OutW = $clog2(MAX_OUT + 1);
  localparam logic [CntW-1:0] FrameLast = CntW'(FRAME_PIXELS);
  localparam logic [OutW-1:0] MaxOut    = OutW'(MAX_OUT);
  localparam logic [8:0]      StepInc   = 9'(STEP);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StStep, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      ramp_q, ramp_d;
  logic [7:0]      frame_q, frame_d;
  logic [CntW-1:0] issued_q, issued_d;
  logic [CntW-1:0] completed_q, completed_d;
  logic [OutW-1:0] out_q, out_d;
  logic            m_valid_q;
  logic [23:0]     m_rgb1_q, m_rgb2_q;

  // Index 0 is stream 1, index 1 is stream 2.
  logic [23:0] mem_q  [2][4];
  logic [1:0]  wptr_q [2];
  logic [1:0]  rptr_q [2];
  logic [2:0]  cnt_q  [2];
  logic [23:0] in_rgb [2];
  logic [1:0]  in_valid, ready, push, avail;

  logic       run_phase, flush, issue, ret;
  logic [8:0] ramp_sum;

  assign in_valid  = {bus.s2_valid, bus.s1_valid};
  assign in_rgb[0] = bus.s1_rgb;
  assign in_rgb[1] = bus.s2_rgb;
  assign run_phase = (state_q == StRun) || (state_q == StDrain);
  // Beats still buffered when the sequence ends are discarded.
  assign flush     = (state_q == StDone);

  always_comb begin
    ready = '0;
    push  = '0;
    avail = '0;
    for (int i = 0; i < 2; i++) begin
      // Ready is from the registered count, so a same-cycle pop cannot raise it.
      ready[i] = run_phase && (cnt_q[i] != 3'd4);
      push[i]  = ready[i] && in_valid[i];
      avail[i] = (cnt_q[i] != 3'd0);
    end
  end

  assign issue = (state_q == StRun) && (&avail) && (out_q < MaxOut) && (issued_q < FrameLast);
  // A result strobe with nothing in flight is ignored.
  assign ret   = bus.merger_out_valid && (out_q != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= 2'd0;
        rptr_q[i] <= 2'd0;
        cnt_q[i]  <= 3'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + 2'd1;
        if (issue)   rptr_q[i] <= rptr_q[i] + 2'd1;
        cnt_q[i] <= cnt_q[i] + {2'b00, push[i]} - {2'b00, issue};
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= in_rgb[i];
    end
  end

  assign ramp_sum = {1'b0, ramp_q} + StepInc;

  always_comb begin
    state_d     = state_q;
    ramp_d      = ramp_q;
    frame_d     = frame_q;
    issued_d    = issued_q + CntW'(issue);
    completed_d = completed_q + CntW'(ret);
    out_d       = out_q;
    if (issue && !ret) begin
      out_d = out_q + 1'b1;
    end else if (ret && !issue) begin
      out_d = out_q - 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StRun;
          ramp_d      = 8'd0;
          frame_d     = 8'd0;
          issued_d    = '0;
          completed_d = '0;
        end
      end
      StRun: begin
        if (issued_q == FrameLast) state_d = StDrain;
      end
      StDrain: begin
        if ((completed_q == FrameLast) && (out_q == '0)) state_d = StStep;
      end
      StStep: begin
        if (ramp_q == 8'hFF) begin
          state_d = StDone;
        end else begin
          ramp_d      = ramp_sum[8] ? 8'hFF : ramp_sum[7:0];
          frame_d     = frame_q + 8'd1;
          issued_d    = '0;
          completed_d = '0;
          state_d     = StRun;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ramp_q      <= 8'd0;
      frame_q     <= 8'd0;
      issued_q    <= '0;
      completed_q <= '0;
      out_q       <= '0;
      m_valid_q   <= 1'b0;
      m_rgb1_q    <= 24'd0;
      m_rgb2_q    <= 24'd0;
    end else begin
      state_q     <= state_d;
      ramp_q      <= ramp_d;
      frame_q     <= frame_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      out_q       <= out_d;
      m_valid_q   <= issue;
      if (issue) begin
        m_rgb1_q <= mem_q[0][rptr_q[0]];
        m_rgb2_q <= mem_q[1][rptr_q[1]];
      end
    end
  end

  assign bus.s1_ready = ready[0];
  assign bus.s2_ready = ready[1];
  assign bus.m_valid  = m_valid_q;
  assign bus.m_rgb1   = m_rgb1_q;
  assign bus.m_rgb2   = m_rgb2_q;
  assign bus.weight2  = ramp_q;
  assign bus.weight1  = ~ramp_q;
  assign busy         = (state_q == StRun) || (state_q == StDrain) || (state_q == StStep);
  assign done         = (state_q == StDone);
  assign frame_cnt    = frame_q;

endmodule

// File: doc/merge_crossfade_scheduler.md
MERGE_CROSSFADE_SCHEDULER -- requirements
Module: merge_crossfade_scheduler

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 16, pixel pairs per frame (width*height).
REQ-002 SHALL have parameter STEP, default 8, weight2 increment per frame.
REQ-003 SHALL have parameter MAX_OUT, default 3, maximum pairs issued to the merger without a returned result.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a crossfade sequence.
REQ-007 SHALL have ports s1_valid in 1, s1_rgb in 24, s1_ready out 1  stream 1 ({R,G,B}, R in [23:16]).
REQ-008 SHALL have ports s2_valid in 1, s2_rgb in 24, s2_ready out 1  stream 2, same packing.
REQ-009 SHALL have ports m_valid out 1, m_rgb1 out 24, m_rgb2 out 24  pair issued to the merger; m_valid drives both data1_valid and data2_valid.
REQ-010 SHALL have ports weight1 out 8, weight2 out 8  merger weights.
REQ-011 SHALL have port merger_out_valid  in  1  merger result strobe, one per issued pair.
REQ-012 SHALL have ports busy out 1, done out 1, frame_cnt out 8  status.

Function
REQ-013 Each stream SHALL have its own 4-deep FIFO; a beat is accepted when valid and ready are both high at a clock edge.
REQ-014 sN_ready SHALL be high only when its FIFO is not full and state is RUN or DRAIN; a pop in the same cycle SHALL NOT raise ready.
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN, STEP, DONE.
REQ-016 IDLE->RUN on start; start SHALL be ignored in every other state.
REQ-017 In RUN, a pair SHALL issue when both FIFOs are non-empty, outstanding < MAX_OUT, and issued < FRAME_PIXELS; both FIFOs pop together.
REQ-018 An issued pair SHALL appear as a one-cycle registered m_valid pulse with m_rgb1/m_rgb2 equal to the popped heads; a beat accepted at edge E SHALL reach m_valid no earlier than after edge E+1.
REQ-019 When only one FIFO has data, nothing SHALL issue and that FIFO SHALL hold its data.
REQ-020 outstanding SHALL increment on issue, decrement on merger_out_valid, hold when both occur in the same cycle, and never go below 0; merger_out_valid with outstanding=0 SHALL be ignored.
REQ-021 RUN->DRAIN when issued reaches FRAME_PIXELS; DRAIN->STEP when completed reaches FRAME_PIXELS and outstanding=0.
REQ-022 In STEP, if ramp = 255: SHALL go to DONE and pulse done for one cycle. Otherwise: ramp SHALL become min(ramp+STEP, 255) (9-bit sum, saturated), frame_cnt SHALL increment (wrap at 255), issued/completed SHALL clear, and the FSM SHALL return to RUN.
REQ-023 weight2 SHALL equal ramp and weight1 SHALL equal 255-ramp; both SHALL change only in STEP, never while pairs are outstanding.
REQ-024 On start, ramp SHALL be 0 and frame_cnt 0.
REQ-025 DONE->IDLE after one cycle; FIFO contents left in DONE SHALL be flushed.
REQ-026 busy SHALL be high in RUN, DRAIN and STEP, and low in IDLE and DONE.

Reset
REQ-027 rst SHALL force IDLE, flush both FIFOs, clear outstanding/issued/completed/ramp/frame_cnt, and take precedence over every other input, including mid-frame.
REQ-028 Reset values SHALL be: s1_ready=s2_ready=0, m_valid=0, m_rgb1=m_rgb2=0, weight1=255, weight2=0, busy=0, done=0, frame_cnt=0.

Verification
REQ-029 FRAME_PIXELS=4, STEP=128, both streams always valid, merger returns each pair 2 cycles later -> 3 frames with weight2 = 0, 128, 255 (weight1 = 255, 127, 0), 12 m_valid pulses, one done pulse, frame_cnt ends at 2.
REQ-030 s1 supplies 4 beats, s2 silent -> no m_valid and s1_ready falls after 4 beats; then s2 supplies 4 beats -> 4 pairs issue in order, each m_rgb1 paired with the matching m_rgb2 by index.
REQ-031 merger_out_valid tied low -> exactly MAX_OUT=3 m_valid pulses, then stall; one merger_out_valid -> exactly one more issue.
REQ-032 Issue and merger_out_valid in the same cycle -> outstanding unchanged; merger_out_valid while IDLE -> no state change.
REQ-033 rst asserted mid-frame with 2 pairs outstanding -> next cycle all outputs at reset values; a later start runs frame 0 with weight2=0.
REQ-034 start pulsed while busy -> ignored, and the ramp sequence is identical to REQ-029.
